// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: push-button driven display-mode controller for the
// two-LED starter kit. Debounces the raw button, classifies short/long
// presses, steps the display from a free-running prescaled tick and drives
// registered LED and MODE outputs.
module led_mode_sequencer #(
  parameter int DB_CYCLES  = 500000,
  parameter int TICK_DIV   = 131072,
  parameter int LONG_TICKS = 256,
  parameter int PWM_BITS   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PB_SW,
  output logic [1:0] LED,
  output logic [1:0] MODE
);

  localparam int DB_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_BLINK = 2'd1,
    M_SHIFT = 2'd2,
    M_DIM   = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------
  // Button synchroniser and debounce
  // ---------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic            pb_stable_q, pb_stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_mismatch, db_done;
  logic            press_p, release_p;

  // Two-flop synchroniser; idle level (released) is 1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= PB_SW;
      sync2_q <= sync1_q;
    end
  end

  assign db_mismatch = (sync2_q != pb_stable_q);
  assign db_done     = db_mismatch && (db_cnt_q == DB_LAST);
  // Events fire in the cycle the stable level is about to flip.
  assign press_p     = db_done &  pb_stable_q;
  assign release_p   = db_done & ~pb_stable_q;

  // Qualify a level change only after DB_CYCLES consecutive mismatching cycles.
  always_comb begin
    db_cnt_d    = '0;
    pb_stable_d = pb_stable_q;
    if (db_mismatch) begin
      if (db_cnt_q == DB_LAST) pb_stable_d = sync2_q;
      else                     db_cnt_d    = db_cnt_q + 1'b1;
    end
  end

  // Debounce state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pb_stable_q <= 1'b1;
      db_cnt_q    <= '0;
    end else begin
      pb_stable_q <= pb_stable_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Display-tick prescaler (free-running, never restarted by mode changes)
  // ---------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Wrap the prescaler at TICK_DIV-1.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge CLK) begin
    if (RESET) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  // ---------------------------------------------------------------------
  // Long-press timer
  // ---------------------------------------------------------------------
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_seen_q, long_seen_d;
  logic              long_fire;

  // One-shot: the tick that brings hold_cnt to LONG_TICKS while held.
  assign long_fire = ~pb_stable_q & tick & ~long_seen_q & (hold_cnt_q == HOLD_LAST);

  // Count ticks of continuous hold, saturating at LONG_TICKS.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    long_seen_d = long_seen_q;
    if (press_p) begin
      hold_cnt_d  = '0;
      long_seen_d = 1'b0;
    end else if (~pb_stable_q && tick && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    if (long_fire) long_seen_d = 1'b1;
  end

  // Hold timer register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_cnt_q  <= '0;
      long_seen_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      long_seen_q <= long_seen_d;
    end
  end

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------
  mode_e mode_q, mode_d;
  logic  advance, entry;

  // A short press advances on release; a release after a long press is swallowed.
  assign advance = release_p & ~long_seen_q;
  assign entry   = long_fire | advance;

  // Next-mode selection; long press forcing OFF wins over a coincident release.
  always_comb begin
    mode_d = mode_q;
    if (long_fire) begin
      mode_d = M_OFF;
    end else if (advance) begin
      case (mode_q)
        M_OFF:   mode_d = M_BLINK;
        M_BLINK: mode_d = M_SHIFT;
        M_SHIFT: mode_d = M_DIM;
        default: mode_d = M_OFF;
      endcase
    end
  end

  // Mode state register.
  always_ff @(posedge CLK) begin
    if (RESET) mode_q <= M_OFF;
    else       mode_q <= mode_d;
  end

  // ---------------------------------------------------------------------
  // Display pattern state
  // ---------------------------------------------------------------------
  logic                phase_q, phase_d;
  logic [1:0]          shift_q, shift_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_up_q, dir_up_d;

  // Per-mode pattern stepping; mode entry reinitialises and beats a same-cycle tick.
  always_comb begin
    phase_d   = phase_q;
    shift_d   = shift_q;
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    dir_up_d  = dir_up_q;
    if (entry) begin
      phase_d   = 1'b0;
      shift_d   = 2'b10;
      pwm_cnt_d = '0;
      duty_d    = '0;
      dir_up_d  = 1'b1;
    end else begin
      if (mode_q == M_DIM) pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (tick) begin
        case (mode_q)
          M_BLINK: phase_d = ~phase_q;
          M_SHIFT: shift_d = {shift_q[0], shift_q[1]};
          M_DIM: begin
            // Triangle ramp; each endpoint is held for one tick while turning.
            if (dir_up_q) begin
              if (duty_q == DUTY_MAX) dir_up_d = 1'b0;
              else                    duty_d   = duty_q + 1'b1;
            end else begin
              if (duty_q == '0) dir_up_d = 1'b1;
              else              duty_d   = duty_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pattern state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q   <= 1'b0;
      shift_q   <= 2'b10;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      dir_up_q  <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      dir_up_q  <= dir_up_d;
    end
  end

  // ---------------------------------------------------------------------
  // LED output
  // ---------------------------------------------------------------------
  logic [1:0] led_q, led_d;

  // LED value derived from current registered state; lands one cycle later.
  always_comb begin
    led_d = 2'b00;
    case (mode_q)
      M_BLINK: led_d = {phase_q, phase_q};
      M_SHIFT: led_d = shift_q;
      M_DIM:   led_d = {2{pwm_cnt_q < duty_q}};
      default: led_d = 2'b00;
    endcase
  end

  // LED output register.
  always_ff @(posedge CLK) begin
    if (RESET) led_q <= 2'b00;
    else       led_q <= led_d;
  end

  assign LED  = led_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with small timing parameters
// (DB_CYCLES=4, TICK_DIV=8, LONG_TICKS=4). Expected values are indexed by
// the number of non-reset clock edges since reset release; ticks land on
// edges that are multiples of 8.
module tb_led_mode_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       PB_SW;
  logic [1:0] LED;
  logic [1:0] MODE;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  led_mode_sequencer #(
    .DB_CYCLES (4),
    .TICK_DIV  (8),
    .LONG_TICKS(4),
    .PWM_BITS  (4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .PB_SW(PB_SW),
    .LED  (LED),
    .MODE (MODE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (!RESET) cnt <= cnt + 1;

  initial begin
    #60000;
    $display("FAIL watchdog expired at cnt=%0d", cnt);
    $fatal(1, "timeout");
  end

  typedef struct {
    int         cyc;
    logic       pb;
    logic [1:0] mode;
    logic [1:0] led;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cnt=%0d actual=%0d expected=%0d", nm, cnt, act, exp);
    end
  endtask

  // Advance to the negedge following edge c.
  task automatic go(input int c);
    int guard = 0;
    while (cnt < c && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    if (cnt != c) begin
      checks++;
      errors++;
      $display("FAIL go_bound actual=%0d expected=%0d", cnt, c);
    end
  endtask

  task automatic add(input int c, input logic pb, input logic [1:0] m, input logic [1:0] l);
    vec_t v;
    v.cyc = c; v.pb = pb; v.mode = m; v.led = l;
    tbl.push_back(v);
  endtask

  // Short press: low at a, high at b.
  task automatic short_press(input int a, input int b);
    go(a); PB_SW = 1'b0;
    go(b); PB_SW = 1'b1;
  endtask

  initial begin
    int dj;
    int st;
    int expc;
    int cntw;

    // {edge, PB drive after check, expected MODE, expected LED}
    add(  0, 0, 0, 2'b00); // glitch start
    add(  2, 1, 0, 2'b00); // glitch end after 2 cycles
    add( 10, 0, 0, 2'b00); // press 1
    add( 30, 1, 0, 2'b00); // release 1
    add( 35, 1, 0, 2'b00);
    add( 36, 1, 1, 2'b00); // BLINK
    add( 37, 1, 1, 2'b00);
    add( 40, 1, 1, 2'b00);
    add( 41, 1, 1, 2'b11);
    add( 48, 1, 1, 2'b11);
    add( 49, 1, 1, 2'b00);
    add( 50, 0, 1, 2'b00); // press 2
    add( 57, 0, 1, 2'b11);
    add( 70, 1, 1, 2'b00); // release 2
    add( 75, 1, 1, 2'b11);
    add( 76, 1, 2, 2'b11); // SHIFT
    add( 77, 1, 2, 2'b10);
    add( 80, 1, 2, 2'b10);
    add( 81, 1, 2, 2'b01);
    add( 89, 1, 2, 2'b10);
    add( 90, 0, 2, 2'b10); // press 3
    add(110, 1, 2, 2'b10); // release 3
    add(116, 1, 3, 2'b01); // DIM
    add(117, 1, 3, 2'b00);
    add(124, 1, 3, 2'b00);
    add(130, 0, 3, 2'b00); // press 4
    add(133, 0, 3, 2'b11);
    add(134, 0, 3, 2'b11);
    add(135, 0, 3, 2'b00);
    add(150, 1, 3, 2'b11); // release 4
    add(155, 1, 3, 2'b00);
    add(156, 1, 0, 2'b00); // OFF
    add(157, 1, 0, 2'b00);

    RESET = 1'b1;
    PB_SW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("reset_led", LED, 2'b00);
      chk("reset_mode", MODE, 2'd0);
    end
    RESET = 1'b0;

    foreach (tbl[k]) begin
      go(tbl[k].cyc);
      chk($sformatf("vec%0d_mode", tbl[k].cyc), MODE, tbl[k].mode);
      chk($sformatf("vec%0d_led", tbl[k].cyc), LED, tbl[k].led);
      PB_SW = tbl[k].pb;
    end

    // Long press in BLINK forces OFF on the 4th tick of hold; release is swallowed.
    short_press(170, 190);
    go(195); chk("lp_pre_mode", MODE, 2'd0);
    go(196); chk("lp_blink_mode", MODE, 2'd1);
    go(210); PB_SW = 1'b0;
    go(247); chk("lp_before_mode", MODE, 2'd1);
    go(248); chk("lp_off_mode", MODE, 2'd0);
    go(249); chk("lp_off_led", LED, 2'b00);
    go(270); PB_SW = 1'b1;
    go(280); chk("lp_release_mode", MODE, 2'd0);
    chk("lp_release_led", LED, 2'b00);

    // Enter DIM exactly on a tick edge (392) so PWM windows align to halves.
    short_press(290, 310);
    go(316); chk("dim_path_blink", MODE, 2'd1);
    short_press(330, 350);
    go(356); chk("dim_path_shift", MODE, 2'd2);
    short_press(370, 386);
    go(391); chk("dim_pre_mode", MODE, 2'd2);
    go(392); chk("dim_mode", MODE, 2'd3);
    for (int j = 0; j < 19; j++) begin
      dj = (j <= 15) ? j : ((j == 16) ? 15 : 31 - j);
      st = (j % 2) * 8;
      expc = 0;
      for (int i = 0; i < 8; i++) if (st + i < dj) expc++;
      cntw = 0;
      for (int i = 0; i < 8; i++) begin
        go(393 + 8 * j + i);
        if (LED == 2'b11) cntw++;
      end
      chk($sformatf("dim_win%0d_duty%0d", j, dj), cntw, expc);
    end

    // Reset during SHIFT with the button held, then release after reset.
    short_press(550, 570);
    go(576); chk("rst_path_off", MODE, 2'd0);
    short_press(590, 610);
    short_press(630, 650);
    go(660); chk("rst_path_shift", MODE, 2'd2);
    go(670); PB_SW = 1'b0;
    go(690); RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_led", LED, 2'b00);
    chk("midrst_mode", MODE, 2'd0);
    @(negedge CLK);
    chk("midrst_mode2", MODE, 2'd0);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    chk("held_after_rst_mode", MODE, 2'd0);
    chk("held_after_rst_led", LED, 2'b00);
    PB_SW = 1'b1;
    repeat (5) @(negedge CLK);
    chk("rel_after_rst_pre", MODE, 2'd0);
    @(negedge CLK);
    chk("rel_after_rst_mode", MODE, 2'd1);
    repeat (4) @(negedge CLK);
    chk("rel_after_rst_hold", MODE, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Sequences the starter-kit LED pair through selectable display modes under push-button control. The block replaces free-running display logic with a controller that owns the LED resource. It debounces the raw push-button, classifies short and long presses, schedules display steps from a prescaled tick, and drives registered LED outputs. It sits between the board push-button pin and the LED pins, in the top-level fabric, on the fabric clock.

Parameters:
DB_CYCLES, 500000, debounce qualification time in CLK cycles (10 ms at 50 MHz); legal >= 2
TICK_DIV, 131072, CLK cycles per display tick; legal >= 2
LONG_TICKS, 256, ticks of continuous hold that constitute a long press; legal >= 1
PWM_BITS, 4, width of the DIM-mode PWM counter and duty level

Ports:
CLK  input  1  fabric clock; all logic on rising edge
RESET  input  1  synchronous reset, active-high
PB_SW  input  1  raw push-button, active-low (0 = depressed), asynchronous to CLK
LED  output  2  LED drive, 1 = on, registered
MODE  output  2  current mode: 0 OFF, 1 BLINK, 2 SHIFT, 3 DIM, registered

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - LED=00, MODE=0.
  - Synchroniser flops=1, pb_stable=1, all counters=0.
  - Shift pattern=10, duty=0, ramp direction=up, long_seen=0.
- Synchroniser: two flops on PB_SW. Debounce and control use only the second flop.
- Debounce:
  - When sync != pb_stable, db_cnt increments. When db_cnt reaches DB_CYCLES-1, pb_stable takes sync and db_cnt clears.
  - Any cycle with sync == pb_stable clears db_cnt, so glitches shorter than DB_CYCLES never propagate.
  - press_p: one-cycle pulse on a pb_stable 1->0 transition. release_p: one-cycle pulse on a 0->1 transition.
- Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps. tick is a one-cycle pulse when tick_cnt == TICK_DIV-1. It free-runs in all modes and is not reset on mode change.
- Hold timer:
  - press_p clears hold_cnt and long_seen.
  - While pb_stable=0, each tick increments hold_cnt, which saturates at LONG_TICKS.
  - When hold_cnt reaches LONG_TICKS: mode goes to OFF in that same cycle and long_seen=1 (one-shot per press).
- Mode FSM:
  - On release_p with long_seen=0, mode advances OFF->BLINK->SHIFT->DIM->OFF (wraps).
  - On release_p with long_seen=1, mode does not change.
  - Mode changes on release only, never on press.
- Mode entry (any cycle in which mode changes, including long-press to OFF):
  - blink phase=0, shift=10, pwm_cnt=0, duty=0, direction=up.
  - Entry initialisation has priority over a coincident tick.
- Per-mode next LED value:
  - OFF: 00.
  - BLINK: {phase,phase}; phase toggles on each tick.
  - SHIFT: shift register; rotates on each tick: 10 -> 01 -> 10.
  - DIM: {2{pwm_cnt < duty}}.
    - pwm_cnt (PWM_BITS wide) increments every CLK and wraps.
    - On each tick, duty steps by 1 in the current direction. At 2^PWM_BITS-1 the direction flips to down; at 0 it flips to up (triangle, endpoints held one tick).
    - duty=0 gives LED=00 for the whole period. duty=15 gives 15 of 16 cycles on.
- Latency:
  - LED and MODE are registered: LED reflects internal state one CLK after it changes; MODE updates on the CLK edge after release_p.
  - Raw PB_SW edge to release_p is 2 sync + DB_CYCLES cycles.
- Reset mid-hold or mid-mode: returns to the reset state next edge; no press or release event is generated by reset itself.
- The block tolerates a button held through reset deassertion. pb_stable starts at 1, so a held button produces one press_p after debounce, and a mode advance occurs only on its later release.

Test Plan:
- Sim params DB_CYCLES=4, TICK_DIV=8, LONG_TICKS=4, PWM_BITS=4. Hold RESET 3 cycles -> LED=00, MODE=0 during and after reset, no pulses.
- PB_SW low 2 cycles then high (glitch < DB_CYCLES) -> no press_p, MODE stays 0.
- Four short presses (low 20 cycles, high 20 cycles) -> MODE steps 1,2,3,0. In BLINK, LED toggles 00/11 every 8 cycles starting 00. In SHIFT, LED starts 10 and alternates 10/01 every 8 cycles.
- In BLINK, hold PB_SW low 60 cycles (>= 4 ticks after debounce), then release -> MODE=0 at the 4th tick of hold; release leaves MODE=0; LED=00.
- In DIM, observe 17 ticks -> duty sequence 0,1..15,15 then descending; LED high-count per 16-cycle PWM window equals duty.
- Assert RESET while in SHIFT with button held -> next edge LED=00, MODE=0. Release after reset deasserts -> one press_p/release_p pair, MODE=1.
